pipe_stage: RTL and testbench
=============================

PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of the datapath payload.
REQ-002 SHALL have parameter CTRL_W, default 15: width of the control payload (mux/mem/alu fields packed).
REQ-003 SHALL have parameter SKID, default 1: 1 = two-entry skid stage, 0 = single-entry stage.
REQ-004 clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 flush  in  1  synchronous squash of all held entries.
REQ-007 in_valid  in  1  upstream beat present.
REQ-008 in_ready  out  1  stage accepts a beat this cycle.
REQ-009 in_data  in  DATA_W  upstream data payload.
REQ-010 in_ctrl  in  CTRL_W  upstream control payload.
REQ-011 out_valid  out  1  downstream beat present.
REQ-012 out_ready  in  1  downstream accepts a beat this cycle.
REQ-013 out_data  out  DATA_W  head-entry data payload.
REQ-014 out_ctrl  out  CTRL_W  head-entry control payload.
REQ-015 occupancy  out  2  number of valid entries, 0..2.

Function
REQ-016 A beat SHALL be accepted when in_valid and in_ready are both 1, and delivered when out_valid and out_ready are both 1.
REQ-017 Storage: main entry (head) plus, when SKID=1, one skid entry; each entry carries a valid bit, data and ctrl.
REQ-018 SKID=1: in_ready SHALL be a registered signal equal to NOT skid_valid, with no combinational path from out_ready.
REQ-019 SKID=0: in_ready SHALL equal (NOT main_valid) OR out_ready.
REQ-020 Head load: when the head is empty or being delivered, the head SHALL load the skid entry if valid, else the accepted input beat, else become invalid.
REQ-021 An accepted beat arriving while the head is full and not delivered SHALL go to the skid entry (SKID=1 only).
REQ-022 Beats SHALL leave in acceptance order; no beat is dropped or duplicated except by flush/reset.
REQ-023 Latency: a beat accepted in cycle N SHALL appear on out_* in cycle N+1 when the stage was empty.
REQ-024 Throughput: with out_ready held 1, one beat per cycle SHALL be sustained with occupancy never exceeding 1.
REQ-025 out_valid SHALL equal main_valid; out_data and out_ctrl SHALL be all-zero whenever out_valid is 0 (bubble = NOP control).
REQ-026 occupancy SHALL equal main_valid + skid_valid; with SKID=0 it never exceeds 1.
REQ-027 flush SHALL take priority over every transfer: the next cycle has occupancy 0, and a beat presented during the flush cycle is discarded even if in_ready was 1.
REQ-028 A delivery handshake coinciding with flush SHALL count as delivered; the downstream stage owns its own squash.
REQ-029 in_ready SHALL be 1 in the cycle after flush.

Reset
REQ-030 When reset is 1 at a clock edge, both valid bits, occupancy and all payload registers SHALL clear to 0.
REQ-031 After reset: out_valid=0, out_data=0, out_ctrl=0, and in_ready=1 from the first post-reset cycle.
REQ-032 Reset SHALL override flush and any in-flight handshake, including mid-burst.

Structure
REQ-033 A shared package SHALL hold the ctrl-field widths (mux 8, mem 3, alu 4), the CTRL_W derivation and the NOP control constant (all-zero).
REQ-034 One sub-module, pipe_entry (valid, data, ctrl register with load/clear), SHALL be instantiated once for the head and once for the skid entry when SKID=1.

Verification
REQ-035 Reset, then in_valid=1 with data 0xDEADBEEF, ctrl 0x1A5 and out_ready=1 -> next cycle out_valid=1, out_data=0xDEADBEEF, out_ctrl=0x1A5, occupancy=1.
REQ-036 Stream 1,2,3,4 with out_ready=1 -> outputs 1,2,3,4 in consecutive cycles, in_ready constantly 1.
REQ-037 SKID=1: accept 0x10 and 0x11, out_ready=0 -> occupancy=2, in_ready=0; raise out_ready -> 0x10 then 0x11 delivered, in_ready returns to 1.
REQ-038 Occupancy 2, assert flush for 1 cycle with in_valid=1 and data 0x99 -> next cycle occupancy=0, out_valid=0, out_data=0, out_ctrl=0, and 0x99 never appears.
REQ-039 Mid-burst reset with occupancy 2 -> next cycle all outputs 0, in_ready=1; a fresh beat 0x5 then delivers normally.
REQ-040 Random valid/ready (SKID 0 and 1) with scoreboard -> in-order, lossless delivery, and no out_* change while out_valid=1 and out_ready=0.

Source files
------------

// File: rtl/pipe_stage_pkg.sv
// pipe_stage_pkg: control field widths, packed control width and the NOP control word shared by the pipe stage
package pipe_stage_pkg;
  localparam int MUX_W = 8;
  localparam int MEM_W = 3;
  localparam int ALU_W = 4;
  localparam int CTRL_BITS = MUX_W + MEM_W + ALU_W;
  localparam logic [CTRL_BITS-1:0] NOP_CTRL = '0;
endpackage

// File: rtl/pipe_entry.sv
// pipe_entry: one valid/data/ctrl register; clock, reset, clear (squash), load strobe, *_d next values, valid/data/ctrl held values
module pipe_entry
  import pipe_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = CTRL_BITS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              valid_d,
  input  logic [DATA_W-1:0] data_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= CTRL_W'(NOP_CTRL);
    end else if (load) begin
      valid <= valid_d;
      data  <= data_d;
      ctrl  <= ctrl_d;
    end
  end
endmodule

// File: rtl/pipe_stage.sv
// pipe_stage: valid/ready pipeline register with optional skid entry; clock, reset, flush, in_* upstream beat, out_* head beat, occupancy 0..2
module pipe_stage
  import pipe_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = CTRL_BITS,
  parameter int SKID   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);
  logic              main_valid, skid_valid, acc, head_free, h_valid;
  logic [DATA_W-1:0] main_data, skid_data, h_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, h_ctrl;
  assign in_ready  = (SKID != 0) ? ~skid_valid : (~main_valid | out_ready);
  assign acc       = in_valid & in_ready & ~flush;
  assign head_free = ~main_valid | out_ready;
  always_comb begin
    h_valid = skid_valid | acc;
    h_data  = skid_valid ? skid_data : acc ? in_data : '0;
    h_ctrl  = skid_valid ? skid_ctrl : acc ? in_ctrl : CTRL_W'(NOP_CTRL);
  end
  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clock  (clock),
    .reset  (reset),
    .clear  (flush),
    .load   (head_free),
    .valid_d(h_valid),
    .data_d (h_data),
    .ctrl_d (h_ctrl),
    .valid  (main_valid),
    .data   (main_data),
    .ctrl   (main_ctrl)
  );
  generate
    if (SKID != 0) begin : g_skid
      logic s_take;
      assign s_take = acc & ~head_free;
      pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clock  (clock),
        .reset  (reset),
        .clear  (flush),
        .load   (head_free | acc),
        .valid_d(s_take),
        .data_d (s_take ? in_data : '0),
        .ctrl_d (s_take ? in_ctrl : CTRL_W'(NOP_CTRL)),
        .valid  (skid_valid),
        .data   (skid_data),
        .ctrl   (skid_ctrl)
      );
    end else begin : g_noskid
      assign skid_valid = 1'b0;
      assign skid_data  = '0;
      assign skid_ctrl  = '0;
    end
  endgenerate
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: queue-model scoreboard for SKID=1 and SKID=0 stages driven by shared stimulus, plus literal directed checks
module tb_pipe_stage;
  logic        clock = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic [14:0] in_ctrl;
  logic        rdy1, vld1, rdy0, vld0;
  logic [31:0] dat1, dat0;
  logic [14:0] ctl1, ctl0;
  logic [1:0]  occ1, occ0;
  logic [46:0] q1[$], q0[$];
  bit          r1, r0;
  int          tests = 0, fails = 0;
  always #5 clock = ~clock;
  pipe_stage #(.DATA_W(32), .CTRL_W(15), .SKID(1)) dut1 (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(vld1), .out_ready(out_ready),
    .out_data(dat1), .out_ctrl(ctl1), .occupancy(occ1)
  );
  pipe_stage #(.DATA_W(32), .CTRL_W(15), .SKID(0)) dut0 (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(vld0), .out_ready(out_ready),
    .out_data(dat0), .out_ctrl(ctl0), .occupancy(occ0)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  // Model: a beat queue per stage; deliver pops the head, accept pushes the tail, flush/reset empty it.
  always @(posedge clock) begin
    r1 = q1.size() < 2;
    r0 = q0.size() == 0 || out_ready;
    if (reset || flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (q1.size() > 0 && out_ready) void'(q1.pop_front());
      if (in_valid && r1) q1.push_back({in_ctrl, in_data});
      if (q0.size() > 0 && out_ready) void'(q0.pop_front());
      if (in_valid && r0) q0.push_back({in_ctrl, in_data});
    end
  end
  always @(negedge clock) begin
    chk("s1_in_ready", 64'(rdy1), 64'(q1.size() < 2));
    chk("s1_out_valid", 64'(vld1), 64'(q1.size() > 0));
    chk("s1_out_data", 64'(dat1), q1.size() > 0 ? 64'(q1[0][31:0]) : 64'd0);
    chk("s1_out_ctrl", 64'(ctl1), q1.size() > 0 ? 64'(q1[0][46:32]) : 64'd0);
    chk("s1_occupancy", 64'(occ1), 64'(q1.size()));
    chk("s0_in_ready", 64'(rdy0), 64'(q0.size() == 0 || out_ready));
    chk("s0_out_valid", 64'(vld0), 64'(q0.size() > 0));
    chk("s0_out_data", 64'(dat0), q0.size() > 0 ? 64'(q0[0][31:0]) : 64'd0);
    chk("s0_out_ctrl", 64'(ctl0), q0.size() > 0 ? 64'(q0[0][46:32]) : 64'd0);
    chk("s0_occupancy", 64'(occ0), 64'(q0.size()));
  end
  task automatic drive(input logic v, input logic [31:0] d, input logic [14:0] c, input logic r, input logic f, input logic rs);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = r;
    flush     = f;
    reset     = rs;
  endtask
  task automatic step();
    @(negedge clock);
  endtask
  task automatic settle();
    #1;
  endtask
  initial begin
    drive(0, 0, 0, 0, 0, 1);
    step(); settle();
    step();
    chk("reset_out_valid", 64'(vld1), 64'd0);
    chk("reset_out_data", 64'(dat1), 64'd0);
    chk("reset_out_ctrl", 64'(ctl1), 64'd0);
    chk("reset_in_ready", 64'({rdy1, rdy0}), 64'b11);
    settle();
    drive(1, 32'hDEADBEEF, 15'h1A5, 1, 0, 0);
    step();
    chk("first_beat_valid", 64'({vld1, vld0}), 64'b11);
    chk("first_beat_data", 64'(dat1), 64'hDEADBEEF);
    chk("first_beat_ctrl", 64'(ctl1), 64'h1A5);
    chk("first_beat_occ", 64'(occ1), 64'd1);
    settle();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 32'(i), 15'(i), 1, 0, 0);
      step();
      chk("stream_data", 64'({dat1, dat0}), {32'(i), 32'(i)});
      chk("stream_in_ready", 64'({rdy1, rdy0}), 64'b11);
      chk("stream_occ", 64'(occ1), 64'd1);
      settle();
    end
    drive(0, 0, 0, 1, 0, 0);
    step(); settle();
    drive(1, 32'h10, 15'h3, 0, 0, 0);
    step(); settle();
    drive(1, 32'h11, 15'h4, 0, 0, 0);
    step();
    chk("skid_occ2", 64'(occ1), 64'd2);
    chk("skid_in_ready_low", 64'(rdy1), 64'd0);
    chk("skid_head_first", 64'(dat1), 64'h10);
    settle();
    drive(0, 0, 0, 1, 0, 0);
    step();
    chk("skid_head_second", 64'(dat1), 64'h11);
    chk("skid_in_ready_back", 64'(rdy1), 64'd1);
    settle();
    step(); settle();
    drive(1, 32'h20, 15'h5, 0, 0, 0);
    step(); settle();
    drive(1, 32'h21, 15'h6, 0, 0, 0);
    step();
    chk("preflush_occ", 64'(occ1), 64'd2);
    settle();
    drive(1, 32'h99, 15'h7, 0, 1, 0);
    step();
    chk("flush_occ", 64'({occ1, occ0}), 64'd0);
    chk("flush_valid", 64'({vld1, vld0}), 64'd0);
    chk("flush_data", 64'({dat1, dat0}), 64'd0);
    chk("flush_ctrl", 64'({ctl1, ctl0}), 64'd0);
    chk("flush_in_ready", 64'({rdy1, rdy0}), 64'b11);
    settle();
    drive(0, 0, 0, 1, 0, 0);
    step();
    chk("flush_no_99", 64'(vld1), 64'd0);
    settle();
    drive(1, 32'h30, 15'h1, 0, 0, 0);
    step(); settle();
    drive(1, 32'h31, 15'h2, 0, 0, 0);
    step(); settle();
    drive(1, 32'h32, 15'h3, 1, 0, 1);
    step();
    chk("midreset_outputs", 64'({vld1, dat1, ctl1, occ1}), 64'd0);
    chk("midreset_in_ready", 64'({rdy1, rdy0}), 64'b11);
    settle();
    drive(1, 32'h5, 15'h9, 1, 0, 0);
    step();
    chk("post_reset_beat", 64'({vld1, dat1}), {31'd0, 1'b1, 32'h5});
    settle();
    for (int n = 0; n < 4000; n++) begin
      drive(1'($urandom_range(0, 99) < 60), $urandom, 15'($urandom), 1'($urandom_range(0, 99) < 55),
            1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 399) == 0));
      step(); settle();
    end
    drive(0, 0, 0, 1, 0, 0);
    step(); step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
